// File: rtl/vga_640x480_rx.sv
// VGA receive timing recovery: sync edge detect, hc/vc recovery, line/frame measurement, lock.
// Optional VGA_RX_AUTOPOL_EN: per-line/per-frame sync polarity detection (default fixed active-low).
module vga_640x480_rx #(
   parameter int CW          = 11,
   parameter int HBP         = 144,
   parameter int HFP         = 784,
   parameter int VBP         = 31,
   parameter int VFP         = 511,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          hsync_in,
   input  logic          vsync_in,
   output logic [CW-1:0] hc,
   output logic [CW-1:0] vc,
   output logic          vidon,
   output logic          locked,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] v_total
);

   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] HB   = CW'(HBP);
   localparam logic [CW-1:0] HF   = CW'(HFP);
   localparam logic [CW-1:0] VB   = CW'(VBP);
   localparam logic [CW-1:0] VF   = CW'(VFP);
   localparam int            NW   = $clog2(LOCK_FRAMES + 1);
   localparam logic [NW-1:0] CNT_LAST = NW'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t        state;
   logic [NW-1:0] cnt;
   logic          hs_s1, hs_s2, hs_d, vs_s1, vs_s2, vs_d;
   logic          hedge, vedge, fb, mism, sat, srch, pchg;
   logic          len_ok, good, lock_set, lock_drop, lock_nxt, win;
   logic          vpend, bad, vvalid;
   logic [1:0]    hseen;
   logic [CW-1:0] hc_inc, vc_inc, hc_nxt, vc_nxt;

   always_ff @(posedge clk) begin
      if (clr) begin
         {hs_s1, hs_s2, hs_d} <= 3'b111;
         {vs_s1, vs_s2, vs_d} <= 3'b111;
      end else begin
         hs_s1 <= hsync_in;
         hs_s2 <= hs_s1;
         hs_d  <= hs_s2;
         vs_s1 <= vsync_in;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
      end
   end

   assign hc_inc = (hc == CMAX) ? CMAX : hc + 1'b1;
   assign vc_inc = (vc == CMAX) ? CMAX : vc + 1'b1;

`ifdef VGA_RX_AUTOPOL_EN
   // pol=1 means active-high; both edge-register taps are normalised the same
   // way so a polarity flip never fabricates an edge.
   logic          hpol, vpol, hpol_new, vpol_new;
   logic [CW-1:0] hhi, vhi;

   assign hedge    = (hs_d ^ hpol) & ~(hs_s2 ^ hpol);
   assign vedge    = (vs_d ^ vpol) & ~(vs_s2 ^ vpol);
   assign hpol_new = hhi < (hc_inc >> 1);
   assign vpol_new = vhi < (vc_inc >> 1);
   assign pchg     = (hedge & (hpol_new != hpol)) | (fb & (vpol_new != vpol));

   always_ff @(posedge clk) begin
      if (clr) begin
         hpol <= 1'b0;
         vpol <= 1'b0;
         hhi  <= '0;
         vhi  <= '0;
      end else begin
         if (hedge) begin
            hpol <= hpol_new;
            hhi  <= {{(CW-1){1'b0}}, hs_s2};
         end else if (hs_s2 && hhi != CMAX) begin
            hhi <= hhi + 1'b1;
         end
         if (fb) begin
            vpol <= vpol_new;
            vhi  <= {{(CW-1){1'b0}}, vs_s2};
         end else if (hedge && vs_s2 && vhi != CMAX) begin
            vhi <= vhi + 1'b1;
         end
      end
   end
`else
   assign hedge = hs_d & ~hs_s2;
   assign vedge = vs_d & ~vs_s2;
   assign pchg  = 1'b0;
`endif

   assign fb        = hedge & (vpend | vedge);
   assign mism      = hedge & (hseen == 2'd2) & (hc_inc != h_total);
   assign sat       = (hc == CMAX) & ~hedge;
   assign srch      = sat | pchg;
   assign len_ok    = ~vvalid | (vc_inc == v_total);
   assign good      = ~bad & ~mism & len_ok;
   assign hc_nxt    = hedge ? '0 : hc_inc;
   assign vc_nxt    = !hedge ? vc : (fb ? '0 : vc_inc);
   assign lock_set  = (state == TRACK) & fb & good & (cnt == CNT_LAST);
   assign lock_drop = srch | ((state == LOCKED) & (mism | (fb & ~len_ok)));
   assign lock_nxt  = (locked | lock_set) & ~lock_drop;
   assign win       = (hc_nxt >= HB) & (hc_nxt < HF) & (vc_nxt >= VB) & (vc_nxt < VF);

   // hseen counts hedges since SEARCH: the first line is partial and the
   // second only establishes h_total, so comparison starts at the third.
   always_ff @(posedge clk) begin
      if (clr) begin
         hc      <= '0;
         vc      <= '0;
         h_total <= '0;
         v_total <= '0;
         vidon   <= 1'b0;
         vpend   <= 1'b0;
         bad     <= 1'b0;
         hseen   <= '0;
      end else begin
         hc    <= hc_nxt;
         vc    <= vc_nxt;
         vidon <= lock_nxt & win;
         if (hedge) h_total <= hc_inc;
         if (fb)    v_total <= vc_inc;
         if (hedge)      vpend <= 1'b0;
         else if (vedge) vpend <= 1'b1;
         if (srch || fb) bad <= 1'b0;
         else if (mism)  bad <= 1'b1;
         if (srch)                        hseen <= '0;
         else if (hedge && hseen != 2'd2) hseen <= hseen + 1'b1;
      end
   end

   // vvalid: a full frame has been measured since SEARCH, so v_total is comparable.
   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= SEARCH;
         cnt    <= '0;
         vvalid <= 1'b0;
         locked <= 1'b0;
      end else begin
         locked <= lock_nxt;
         if (srch) begin
            state  <= SEARCH;
            cnt    <= '0;
            vvalid <= 1'b0;
         end else begin
            case (state)
               SEARCH: if (fb) begin
                  state <= TRACK;
                  cnt   <= '0;
               end
               TRACK: if (fb) begin
                  vvalid <= 1'b1;
                  if (!good) cnt <= '0;
                  else if (cnt == CNT_LAST) begin
                     state <= LOCKED;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               end
               LOCKED: if (mism || (fb && !len_ok)) begin
                  state <= TRACK;
                  cnt   <= '0;
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_640x480_rx.sv
// Directed bench for vga_640x480_rx on a scaled 200x10 raster (hsync low 24 clocks,
// vsync low 2 lines). Pin-to-hc latency is 3, so after driving pixel p, hc = p-2.
module tb_vga_640x480_rx;
   localparam int HT = 200, VT = 10, HS = 24, VS = 2;

   logic        clk = 1'b0;
   logic        clr, hsync_in, vsync_in;
   logic [10:0] hc, vc, h_total, v_total;
   logic        vidon, locked;

   int checks = 0, errs = 0;
   int ln = 0, px = 0, long_ln = -1, lst_ln = -1, lst_px = -1;
   bit vs_early = 1'b0, inv = 1'b0;

   vga_640x480_rx #(.CW(11), .HBP(36), .HFP(196), .VBP(3), .VFP(9), .LOCK_FRAMES(2)) dut (
      .clk(clk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hc(hc), .vc(vc), .vidon(vidon), .locked(locked),
      .h_total(h_total), .v_total(v_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit h, input bit v);
      hsync_in = h;
      vsync_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      int len;
      bit h, v;
      len = (ln == long_ln) ? HT + 1 : HT;
      h = (px < HS) ? 1'b0 : 1'b1;
      v = (ln < VS || (vs_early && ln == VT - 1 && px >= len - 5)) ? 1'b0 : 1'b1;
      lst_ln = ln;
      lst_px = px;
      drive(h ^ inv, v ^ inv);
      px++;
      if (px == len) begin
         px = 0;
         if (ln == long_ln) long_ln = -1;
         ln = (ln + 1) % VT;
      end
   endtask

   // advance to the next occurrence of raster position (l,p)
   task automatic go_to(input int l, input int p);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(lst_ln == l && lst_px == p) && n < 2 * HT * VT + 10);
      if (!(lst_ln == l && lst_px == p)) begin
         checks++;
         errs++;
         $display("FAIL go_to: reached line %0d px %0d, wanted line %0d px %0d", lst_ln, lst_px, l, p);
      end
   endtask

   initial begin
      clr = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hc", hc, 0);
      chk("rst_vc", vc, 0);
      chk("rst_vidon", vidon, 0);
      chk("rst_locked", locked, 0);
      chk("rst_htot", h_total, 0);
      chk("rst_vtot", v_total, 0);
      clr = 1'b0;

      // acquisition and lock on the third frame boundary
      go_to(0, 2);  chk("b1_hc", hc, 0);  chk("b1_vc", vc, 0);
      go_to(1, 2);  chk("l1_vc", vc, 1);  chk("l1_htot", h_total, HT);
      go_to(0, 1);  chk("b2_pre_hc", hc, 199);  chk("b2_pre_vc", vc, 9);  chk("b2_pre_lk", locked, 0);
      go_to(0, 2);  chk("b2_vtot", v_total, VT);  chk("b2_lk", locked, 0);
      go_to(0, 1);  chk("b3_pre_lk", locked, 0);
      go_to(0, 2);  chk("b3_lk", locked, 1);  chk("b3_hc", hc, 0);  chk("b3_vc", vc, 0);

      // visible window edges
      go_to(2, 100);  chk("vid_vc2", vidon, 0);
      go_to(3, 37);   chk("vid_hc35", vidon, 0);
      go_to(3, 38);   chk("vid_hc36", vidon, 1);
      go_to(3, 197);  chk("vid_hc195", vidon, 1);
      go_to(3, 198);  chk("vid_hc196", vidon, 0);
      go_to(8, 100);  chk("vid_vc8", vidon, 1);
      go_to(9, 100);  chk("vid_vc9", vidon, 0);

      // vsync leading edge 5 clocks ahead of hsync, then coincident again
      vs_early = 1'b1;
      go_to(9, 199);  chk("early_vc_hold", vc, 9);
      go_to(0, 1);    chk("early_vc_pend", vc, 9);
      go_to(0, 2);    chk("early_vc0", vc, 0);  chk("early_vtot", v_total, VT);  chk("early_lk", locked, 1);
      vs_early = 1'b0;
      go_to(0, 2);    chk("coinc_vc0", vc, 0);  chk("coinc_vtot", v_total, VT);

      // one long line drops lock, then two clean frames relock
      long_ln = 4;
      go_to(5, 1);  chk("long_pre_lk", locked, 1);
      go_to(5, 2);  chk("long_lk", locked, 0);  chk("long_htot", h_total, HT + 1);  chk("long_hc", hc, 0);
      go_to(0, 2);  chk("long_b1_lk", locked, 0);
      go_to(0, 2);  chk("long_b2_lk", locked, 0);
      go_to(0, 2);  chk("long_relock", locked, 1);  chk("long_htot2", h_total, HT);

      // hsync stuck high: hc saturates, lock lost, vc held
      go_to(3, 50);  chk("sat_pre_lk", locked, 1);  chk("sat_pre_hc", hc, 48);
      repeat (2100) drive(1'b1, 1'b1);
      chk("sat_hc", hc, 2047);  chk("sat_vc", vc, 3);
      chk("sat_lk", locked, 0);  chk("sat_vidon", vidon, 0);
      go_to(4, 2);  chk("sat_htot", h_total, 2047);  chk("sat_vc4", vc, 4);
      go_to(0, 2);  chk("sat_b1_lk", locked, 0);
      go_to(0, 2);  chk("sat_b2_lk", locked, 0);
      go_to(0, 2);  chk("sat_relock", locked, 1);

      // clr pulse mid-frame while locked
      go_to(5, 50);  chk("clr_pre_vc", vc, 5);  chk("clr_pre_lk", locked, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_hc", hc, 0);  chk("clr_vc", vc, 0);  chk("clr_vidon", vidon, 0);
      chk("clr_lk", locked, 0);  chk("clr_htot", h_total, 0);  chk("clr_vtot", v_total, 0);
      go_to(0, 2);  chk("clr_b1_lk", locked, 0);
      go_to(0, 2);  chk("clr_b2_lk", locked, 0);
      go_to(0, 2);  chk("clr_relock", locked, 1);

      // inverted syncs
      inv = 1'b1;
      repeat (5) go_to(0, 2);
      go_to(3, 30);
      chk("inv_htot", h_total, HT);
      chk("inv_lk", locked, 1);
`ifdef VGA_RX_AUTOPOL_EN
      chk("inv_hc", hc, 28);
      chk("inv_vc", vc, 3);
`else
      chk("inv_hc", hc, 4);
      chk("inv_vc", vc, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
